fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core. Generates the fetch PC, issues pipelined reads to the instruction cache, and buffers returned words in a BUF_DEPTH-entry FIFO with a valid/ready interface to decode. Taken-branch and jump redirects are accepted from execute or memory and flush all in-flight work. Replaces the single-register fetch stage and decouples decode backpressure from the cache.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, pipelined icache reads and a BUF_DEPTH-entry
// decode FIFO. Define FETCH_PERF_CNT_EN to add the fetch/flush performance counters.
module fetch_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] PC_RESET  = 32'h0000_2000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_icache_addr,
    output logic            o_icache_re,
    input  logic [31:0]     i_icache_dout,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_fetch_cnt,
    output logic [31:0]     o_perf_flush_cnt
`else
    // counters not built
`endif
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [XLEN-1:0] PC_INIT = XLEN'(PC_RESET);

    logic [XLEN-1:0] r_pc;
    logic            r_pend;
    logic [XLEN-1:0] r_pend_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_fifo_pc    [BUF_DEPTH];
    logic [31:0]     r_fifo_instr [BUF_DEPTH];

    logic            w_redirect;
    logic            w_deq;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [OW-1:0]   w_occ;
    logic [XLEN-1:0] w_target;

    // Valid/ready: the head entry transfers to decode in any unstalled cycle where
    // o_instr_valid and i_instr_ready are both high; o_instr/o_instr_pc are stable while
    // o_instr_valid is high and no transfer occurs.
    assign o_instr_valid = (r_count != '0);
    assign o_instr       = r_fifo_instr[r_rd_ptr];
    assign o_instr_pc    = r_fifo_pc[r_rd_ptr];

    assign w_redirect = i_redirect_valid & ~i_stall;
    assign w_deq      = o_instr_valid & i_instr_ready & ~i_stall;
    assign w_pop      = w_deq & ~w_redirect;
    assign w_push     = r_pend & ~i_stall & ~w_redirect;
    assign w_target   = i_redirect_pc & ~XLEN'(3);

    // Occupancy after this cycle's pop, counting the in-flight response as a reserved slot.
    assign w_occ   = OW'(r_count) + OW'(r_pend) - OW'(w_deq);
    assign w_issue = ~i_reset & ~i_stall & (i_redirect_valid | (w_occ < OW'(BUF_DEPTH)));

    // A stalled redirect must not move the address; it is re-presented once stall drops.
    assign o_icache_addr = w_redirect ? w_target : r_pc;
    assign o_icache_re   = w_issue;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc     <= PC_INIT;
            r_pend   <= 1'b0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (!i_stall) begin
            if (w_issue) begin
                r_pend    <= 1'b1;
                r_pend_pc <= o_icache_addr;
                r_pc      <= o_icache_addr + XLEN'(4);
            end else begin
                r_pend <= 1'b0;
            end
            if (w_redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_fifo_pc[r_wr_ptr]    <= r_pend_pc;
            r_fifo_instr[r_wr_ptr] <= i_icache_dout;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else if (!i_stall) begin
            if (w_pop) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            // Discarded work is every buffered entry plus the response still in flight.
            if (w_redirect) r_perf_flush_cnt <= r_perf_flush_cnt + 32'(r_count) + 32'(r_pend);
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/backpressure traffic,
// checked every cycle against a queue-based behavioural model of the fetch front end.
module tb_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            i_reset;
  logic            i_stall;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic [XLEN-1:0] o_icache_addr;
  logic            o_icache_re;
  logic [31:0]     i_icache_dout;
  logic            o_instr_valid;
  logic            i_instr_ready;
  logic [31:0]     o_instr;
  logic [XLEN-1:0] o_instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     o_perf_fetch_cnt;
  logic [31:0]     o_perf_flush_cnt;
`endif

  fetch_unit #(.XLEN(XLEN), .PC_RESET(32'h0000_2000), .BUF_DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_stall         (i_stall),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_icache_addr   (o_icache_addr),
    .o_icache_re     (o_icache_re),
    .i_icache_dout   (i_icache_dout),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt(o_perf_fetch_cnt),
    .o_perf_flush_cnt(o_perf_flush_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural model: delivered-word queue, one outstanding request, next PC
  logic [63:0] exp_q[$];
  logic        m_pend    = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_fetch_cnt = 32'h0;
  logic [31:0] m_flush_cnt = 32'h0;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  logic        prev_rv = 1'b0;
  logic        prev_st = 1'b0;
  logic [31:0] prev_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic m_deq();
    return (exp_q.size() != 0) && i_instr_ready && !i_stall;
  endfunction

  function automatic logic m_re();
    int occ;
    occ = exp_q.size() + int'(m_pend) - int'(m_deq());
    return !i_reset && !i_stall && (i_redirect_valid || (occ < DEPTH));
  endfunction

  function automatic logic [31:0] m_addr();
    return (i_redirect_valid && !i_stall) ? (i_redirect_pc & ~32'h3) : m_pc;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
  endtask

  // model advances on the active edge using the inputs presented for that cycle
  always @(posedge clk) begin
    logic        re;
    logic [31:0] addr;
    logic        deq;
    re   = m_re();
    addr = m_addr();
    deq  = m_deq();
    if (i_reset) begin
      exp_q.delete();
      m_pend      = 1'b0;
      m_pc        = 32'h0000_2000;
      m_fetch_cnt = 32'h0;
      m_flush_cnt = 32'h0;
    end else if (!i_stall) begin
      if (i_redirect_valid) begin
        m_flush_cnt = m_flush_cnt + 32'(exp_q.size()) + 32'(m_pend);
        exp_q.delete();
      end else begin
        if (deq) begin
          void'(exp_q.pop_front());
          m_fetch_cnt = m_fetch_cnt + 32'd1;
        end
        if (m_pend) exp_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
      end
      if (re) begin
        m_pend    = 1'b1;
        m_pend_pc = addr;
        m_pc      = addr + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  // scoreboard compare, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("icache_re", o_icache_re, m_re());
      chk32("icache_addr", o_icache_addr, m_addr());
      chk1("instr_valid", o_instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk32("instr", o_instr, exp_q[0][31:0]);
        chk32("instr_pc", o_instr_pc, exp_q[0][63:32]);
      end
`ifdef FETCH_PERF_CNT_EN
      chk32("perf_fetch_cnt", o_perf_fetch_cnt, m_fetch_cnt);
      chk32("perf_flush_cnt", o_perf_flush_cnt, m_flush_cnt);
`endif
    end
  end

  // driver: present one cycle of inputs just after the edge, return before the next negedge
  task automatic drive(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    i_reset          = rst;
    i_stall          = st;
    i_redirect_valid = rv;
    i_redirect_pc    = rpc;
    i_instr_ready    = rdy;
    i_icache_dout    = mem_word(m_pend_pc);
    #2;
  endtask

  initial begin
    i_reset          = 1'b1;
    i_stall          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    i_instr_ready    = 1'b0;
    i_icache_dout    = 32'h0;
    chk_en           = 1'b1;

    repeat (3) drive(1, 0, 0, 0, 0);
    chk1("rst_re", o_icache_re, 1'b0);
    chk1("rst_valid", o_instr_valid, 1'b0);
    chk32("rst_addr", o_icache_addr, 32'h0000_2000);

    // release with decode blocked: two entries buffer, then issue stops
    drive(0, 0, 0, 0, 0);
    chk32("first_addr", o_icache_addr, 32'h0000_2000);
    chk1("first_re", o_icache_re, 1'b1);
    drive(0, 0, 0, 0, 0);
    chk32("second_addr", o_icache_addr, 32'h0000_2004);
    repeat (8) drive(0, 0, 0, 0, 0);
    chk1("full_re", o_icache_re, 1'b0);
    chk1("full_valid", o_instr_valid, 1'b1);
    chk32("full_head_pc", o_instr_pc, 32'h0000_2000);
    drive(0, 0, 0, 0, 1);
    chk32("drain_pc0", o_instr_pc, 32'h0000_2000);
    chk32("drain_addr", o_icache_addr, 32'h0000_2008);
    drive(0, 0, 0, 0, 1);
    chk32("drain_pc1", o_instr_pc, 32'h0000_2004);
    drive(0, 0, 0, 0, 1);
    chk32("drain_pc2", o_instr_pc, 32'h0000_2008);

    // redirect with a full buffer; misaligned target
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h0000_3006, 1);
    chk32("redir_addr", o_icache_addr, 32'h0000_3004);
    chk1("redir_re", o_icache_re, 1'b1);
    drive(0, 0, 0, 0, 1);
    chk1("redir_bubble", o_instr_valid, 1'b0);
    drive(0, 0, 0, 0, 1);
    chk1("redir_valid", o_instr_valid, 1'b1);
    chk32("redir_pc", o_instr_pc, 32'h0000_3004);

    // stall with a redirect held across the stall boundary
    repeat (2) drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 1, 32'h0000_5000, 1);
    chk1("stall_re", o_icache_re, 1'b0);
    drive(0, 0, 1, 32'h0000_5000, 1);
    chk32("post_stall_addr", o_icache_addr, 32'h0000_5000);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk32("post_stall_pc", o_instr_pc, 32'h0000_5000);

    // address wrap
    drive(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk32("wrap_addr0", o_icache_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    chk32("wrap_addr1", o_icache_addr, 32'h0000_0000);
    drive(0, 0, 0, 0, 1);
    chk32("wrap_pc0", o_instr_pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    chk32("wrap_pc1", o_instr_pc, 32'h0000_0000);

    // reset with a full buffer
    repeat (4) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk1("rerst_valid", o_instr_valid, 1'b0);
    chk1("rerst_re", o_icache_re, 1'b0);
    drive(0, 0, 0, 0, 1);
    chk32("rerst_addr", o_icache_addr, 32'h0000_2000);

    // random traffic; a redirect seen during stall is held until stall drops
    for (int i = 0; i < 3000; i++) begin
      logic        rst, st, rv, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 70);
      if (prev_rv && prev_st) begin
        rv  = 1'b1;
        rpc = prev_pc;
      end else begin
        rv  = ($urandom_range(0, 99) < 8);
        rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      if (rst) rv = 1'b0;
      prev_rv = rv;
      prev_st = st;
      prev_pc = rpc;
      drive(rst, st, rv, rpc, rdy);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
